// File: rtl/fp2fx_pkg.sv
// Shared FP32 field layout, class encoding and S1->S2 stage record for fp_to_fixed_pipe.
package fp2fx_pkg;

  localparam int FP_W        = 32;
  localparam int MANT_W      = 23;
  localparam int EXP_W       = 8;
  localparam int SIGN_POS    = 31;
  localparam int EXP_LSB     = 23;
  localparam int EXP_BIAS    = 127;
  localparam int EXP_SPECIAL = 255;
  localparam int SH_W        = 10;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  typedef struct packed {
    logic                   sign;
    fp_class_e              cls;
    logic                   mant_nz;
    logic                   big;
    logic [MANT_W:0]        sig;
    logic signed [SH_W-1:0] shamt;
  } s1_t;

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                         input logic [MANT_W-1:0] m);
    fp_class_e c;
    if (e == '0) begin
      c = FP_ZERO;
    end else if (e == EXP_W'(EXP_SPECIAL)) begin
      c = (m == '0) ? FP_INF : FP_NAN;
    end else begin
      c = FP_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp2fx_shifter.sv
// Aligns {1,mantissa} to an N-bit fixed-point magnitude by a signed shift amount.
// With FP2FX_ROUND_EN defined, also produces guard and sticky bits.
module fp2fx_shifter
  import fp2fx_pkg::*;
#(
  parameter int N = 20
) (
  input  logic [MANT_W:0]        sig_i,
  input  logic signed [SH_W-1:0] shamt_i,
  output logic [N-1:0]           mag_o
`ifdef FP2FX_ROUND_EN
  ,
  output logic                   guard_o,
  output logic                   sticky_o
`endif
);

  localparam int SIG_W = MANT_W + 1;
  localparam logic signed [SH_W-1:0] LEFT_LIM = SH_W'(N);

  logic [SH_W-1:0] rsh;
`ifdef FP2FX_ROUND_EN
  logic [2*SIG_W-1:0] right;
`endif

  always_comb begin
    mag_o = '0;
    rsh   = '0;
`ifdef FP2FX_ROUND_EN
    guard_o  = 1'b0;
    sticky_o = 1'b0;
    right    = '0;
`endif
    if (!shamt_i[SH_W-1]) begin
      if (shamt_i < LEFT_LIM) begin
        mag_o = N'({{N{1'b0}}, sig_i} << shamt_i[4:0]);
      end
    end else begin
      rsh = SH_W'(-shamt_i);
      // Beyond SIG_W every significand bit lies below the guard position.
      if (rsh <= SH_W'(SIG_W)) begin
`ifdef FP2FX_ROUND_EN
        right    = {sig_i, {SIG_W{1'b0}}} >> rsh;
        mag_o    = N'(right[2*SIG_W-1:SIG_W]);
        guard_o  = right[SIG_W-1];
        sticky_o = |right[SIG_W-2:0];
`else
        mag_o = N'(sig_i >> rsh);
`endif
      end
`ifdef FP2FX_ROUND_EN
      else begin
        sticky_o = |sig_i;
      end
`endif
    end
  end

endmodule

// File: rtl/fp_to_fixed_pipe.sv
// Three-stage FP32 to sign-magnitude fixed-point converter with valid/ready flow control.
// Define FP2FX_ROUND_EN for round-to-nearest-even; otherwise truncation toward zero.
module fp_to_fixed_pipe
  import fp2fx_pkg::*;
#(
  parameter int INT_W  = 1,
  parameter int FRAC_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FP_W-1:0]   fp_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              sign_o,
  output logic [INT_W-1:0]  integer_o,
  output logic [FRAC_W-1:0] fractional_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              invalid_o
);

  localparam int N = INT_W + FRAC_W;
  localparam logic signed [SH_W-1:0] SH_OFF  = SH_W'(FRAC_W - MANT_W);
  localparam logic signed [SH_W-1:0] INT_LIM = SH_W'(INT_W);

  logic advance;

  logic                   s1_v_d, s1_v_q;
  s1_t                    s1_d, s1_q;
  logic [EXP_W-1:0]       exp_f;
  logic [MANT_W-1:0]      mant_f;
  logic signed [SH_W-1:0] e_unb;

  logic      s2_v_d, s2_v_q;
  logic      s2_sign_d, s2_sign_q;
  fp_class_e s2_cls_d, s2_cls_q;
  logic      s2_mnz_d, s2_mnz_q;
  logic      s2_big_d, s2_big_q;
  logic [N-1:0] s2_mag_d, s2_mag_q;
  logic [N-1:0] sh_mag;
`ifdef FP2FX_ROUND_EN
  logic s2_guard_d, s2_guard_q;
  logic s2_sticky_d, s2_sticky_q;
  logic sh_guard, sh_sticky;
  logic rnd_inc;
  logic [N:0] rnd_sum;
`endif

  logic         out_v_d, out_v_q;
  logic         sign_d, sign_q;
  logic [N-1:0] mag_d, mag_q;
  logic         ovf_d, ovf_q;
  logic         unf_d, unf_q;
  logic         inv_d, inv_q;

  assign advance = !out_v_q || out_ready_i;

  always_comb begin
    s1_d   = s1_q;
    s1_v_d = s1_v_q;
    exp_f  = fp_i[SIGN_POS-1:EXP_LSB];
    mant_f = fp_i[MANT_W-1:0];
    e_unb  = $signed({{(SH_W-EXP_W){1'b0}}, exp_f}) - SH_W'(EXP_BIAS);
    if (advance) begin
      s1_v_d = in_valid_i;
      if (in_valid_i) begin
        s1_d.sign    = fp_i[SIGN_POS];
        s1_d.cls     = classify(exp_f, mant_f);
        s1_d.mant_nz = |mant_f;
        s1_d.big     = (e_unb >= INT_LIM);
        s1_d.sig     = {1'b1, mant_f};
        // Left-shift count that places bit 0 of the significand at weight 2^-FRAC_W.
        s1_d.shamt   = e_unb + SH_OFF;
      end
    end
  end

  fp2fx_shifter #(
    .N(N)
  ) u_shifter (
    .sig_i   (s1_q.sig),
    .shamt_i (s1_q.shamt),
    .mag_o   (sh_mag)
`ifdef FP2FX_ROUND_EN
    ,
    .guard_o (sh_guard),
    .sticky_o(sh_sticky)
`endif
  );

  always_comb begin
    s2_v_d    = s2_v_q;
    s2_sign_d = s2_sign_q;
    s2_cls_d  = s2_cls_q;
    s2_mnz_d  = s2_mnz_q;
    s2_big_d  = s2_big_q;
    s2_mag_d  = s2_mag_q;
`ifdef FP2FX_ROUND_EN
    s2_guard_d  = s2_guard_q;
    s2_sticky_d = s2_sticky_q;
`endif
    if (advance) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_sign_d = s1_q.sign;
        s2_cls_d  = s1_q.cls;
        s2_mnz_d  = s1_q.mant_nz;
        s2_big_d  = s1_q.big;
        s2_mag_d  = sh_mag;
`ifdef FP2FX_ROUND_EN
        s2_guard_d  = sh_guard;
        s2_sticky_d = sh_sticky;
`endif
      end
    end
  end

  always_comb begin
    out_v_d = out_v_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    inv_d   = inv_q;
`ifdef FP2FX_ROUND_EN
    rnd_inc = 1'b0;
    rnd_sum = '0;
`endif
    if (advance) begin
      out_v_d = s2_v_q;
      if (s2_v_q) begin
        sign_d = s2_sign_q;
        mag_d  = '0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        inv_d  = 1'b0;
        case (s2_cls_q)
          FP_ZERO: unf_d = s2_mnz_q;
          FP_NAN: begin
            sign_d = 1'b0;
            inv_d  = 1'b1;
          end
          FP_INF: begin
            mag_d = '1;
            ovf_d = 1'b1;
            inv_d = 1'b1;
          end
          default: begin
            if (s2_big_q) begin
              mag_d = '1;
              ovf_d = 1'b1;
            end else begin
`ifdef FP2FX_ROUND_EN
              rnd_inc = s2_guard_q & (s2_sticky_q | s2_mag_q[0]);
              rnd_sum = {1'b0, s2_mag_q} + {{N{1'b0}}, rnd_inc};
              if (rnd_sum[N]) begin
                mag_d = '1;
                ovf_d = 1'b1;
              end else begin
                mag_d = rnd_sum[N-1:0];
              end
`else
              mag_d = s2_mag_q;
`endif
              unf_d = (mag_d == '0);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_q        <= '0;
      s2_v_q      <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_cls_q    <= FP_ZERO;
      s2_mnz_q    <= 1'b0;
      s2_big_q    <= 1'b0;
      s2_mag_q    <= '0;
`ifdef FP2FX_ROUND_EN
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
`endif
      out_v_q     <= 1'b0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_q        <= s1_d;
      s2_v_q      <= s2_v_d;
      s2_sign_q   <= s2_sign_d;
      s2_cls_q    <= s2_cls_d;
      s2_mnz_q    <= s2_mnz_d;
      s2_big_q    <= s2_big_d;
      s2_mag_q    <= s2_mag_d;
`ifdef FP2FX_ROUND_EN
      s2_guard_q  <= s2_guard_d;
      s2_sticky_q <= s2_sticky_d;
`endif
      out_v_q     <= out_v_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inv_q       <= inv_d;
    end
  end

  assign in_ready_o   = advance;
  assign out_valid_o  = out_v_q;
  assign sign_o       = sign_q;
  assign integer_o    = mag_q[N-1:FRAC_W];
  assign fractional_o = mag_q[FRAC_W-1:0];
  assign overflow_o   = ovf_q;
  assign underflow_o  = unf_q;
  assign invalid_o    = inv_q;

endmodule

// File: tb/tb_fp_to_fixed_pipe.sv
// Directed-vector bench for fp_to_fixed_pipe at INT_W=1, FRAC_W=19.
module tb_fp_to_fixed_pipe;

  localparam int INT_W  = 1;
  localparam int FRAC_W = 19;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       fp_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              sign_o;
  logic [INT_W-1:0]  integer_o;
  logic [FRAC_W-1:0] fractional_o;
  logic              overflow_o;
  logic              underflow_o;
  logic              invalid_o;

  always #5 clk = ~clk;

  fp_to_fixed_pipe #(
    .INT_W (INT_W),
    .FRAC_W(FRAC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fp_i        (fp_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sign_o      (sign_o),
    .integer_o   (integer_o),
    .fractional_o(fractional_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o),
    .invalid_o   (invalid_o)
  );

  typedef struct {
    logic [31:0] fp;
    logic [23:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [23:0] expq[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic [23:0] dut_word;

  assign dut_word = {sign_o, integer_o, fractional_o, overflow_o, underflow_o, invalid_o};

  // {sign, integer, fraction, overflow, underflow, invalid}
  function automatic logic [23:0] pk(input logic s, input logic i, input logic [18:0] f,
                                     input logic o, input logic u, input logic v);
    return {s, i, f, o, u, v};
  endfunction

  function automatic void add(input logic [31:0] fp, input logic [23:0] e);
    vec_t r;
    r.fp  = fp;
    r.exp = e;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  // Every transferred output word is compared against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      if (expq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: actual %h required no output", dut_word);
      end else begin
        chk($sformatf("out%0d", n_out), 32'(dut_word), 32'(expq.pop_front()));
        n_out++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] w, input logic [23:0] e);
    int t;
    t          = 0;
    fp_i       = w;
    in_valid_i = 1'b1;
    @(negedge clk);
    while (!in_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready_o) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready_o 0 for word %h, required 1", w);
    end else begin
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d words outstanding, required 0", expq.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] sw[6];
    logic [23:0] se[6];
    logic [23:0] snap;
    bit          done;
    int          t;

    add(32'h3FC00000, pk(0, 1, 19'h40000, 0, 0, 0));
    add(32'hBE800000, pk(1, 0, 19'h20000, 0, 0, 0));
    add(32'h40000000, pk(0, 1, 19'h7FFFF, 1, 0, 0));
    add(32'h7FC00000, pk(0, 0, 19'h00000, 0, 0, 1));
    add(32'hFF800000, pk(1, 1, 19'h7FFFF, 1, 0, 1));
    add(32'h7F800000, pk(0, 1, 19'h7FFFF, 1, 0, 1));
    add(32'hFFC00001, pk(0, 0, 19'h00000, 0, 0, 1));
    add(32'h80000000, pk(1, 0, 19'h00000, 0, 0, 0));
    add(32'h00000000, pk(0, 0, 19'h00000, 0, 0, 0));
    add(32'h80000001, pk(1, 0, 19'h00000, 0, 1, 0));
    add(32'h3F800000, pk(0, 1, 19'h00000, 0, 0, 0));
    add(32'h3F000000, pk(0, 0, 19'h40000, 0, 0, 0));
    add(32'h36000000, pk(0, 0, 19'h00001, 0, 0, 0));
    add(32'h35000000, pk(0, 0, 19'h00000, 0, 1, 0));
    add(32'h35800000, pk(0, 0, 19'h00000, 0, 1, 0));
    add(32'hC0490FDB, pk(1, 1, 19'h7FFFF, 1, 0, 0));
    add(32'h7F7FFFFF, pk(0, 1, 19'h7FFFF, 1, 0, 0));
    add(32'hBF400000, pk(1, 0, 19'h60000, 0, 0, 0));
    add(32'h3E2AAAAB, pk(0, 0, 19'h15555, 0, 0, 0));
`ifdef FP2FX_ROUND_EN
    add(32'h35C00000, pk(0, 0, 19'h00001, 0, 0, 0));
    add(32'h36400000, pk(0, 0, 19'h00002, 0, 0, 0));
    add(32'h3FFFFFFF, pk(0, 1, 19'h7FFFF, 1, 0, 0));
    add(32'h3F7FFFFF, pk(0, 1, 19'h00000, 0, 0, 0));
`else
    add(32'h35C00000, pk(0, 0, 19'h00000, 0, 1, 0));
    add(32'h36400000, pk(0, 0, 19'h00001, 0, 0, 0));
    add(32'h3FFFFFFF, pk(0, 1, 19'h7FFFF, 0, 0, 0));
    add(32'h3F7FFFFF, pk(0, 0, 19'h7FFFF, 0, 0, 0));
`endif

    rst_n       = 1'b0;
    in_valid_i  = 1'b0;
    fp_i        = '0;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_word", 32'(dut_word), 32'h0);
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_ready", 32'(in_ready_o), 32'h1);
    @(posedge clk);
    #1;

    // Table, full throughput.
    for (int i = 0; i < tbl.size(); i++) send(tbl[i].fp, tbl[i].exp);
    drain();

    // Table again under random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < tbl.size(); i++) send(tbl[i].fp, tbl[i].exp);
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready_i = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
        out_ready_i = 1'b1;
      end
    join
    drain();

    // Back-to-back pair: latency 3 and consecutive outputs.
    out_ready_i = 1'b1;
    fp_i        = 32'hBE800000;
    in_valid_i  = 1'b1;
    expq.push_back(pk(1, 0, 19'h20000, 0, 0, 0));
    @(posedge clk);
    #1;
    fp_i = 32'h40000000;
    expq.push_back(pk(0, 1, 19'h7FFFF, 1, 0, 0));
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    chk("b2b_lat_c2", 32'(out_valid_o), 32'h0);
    @(posedge clk);
    #1;
    chk("b2b_lat_c3", 32'(out_valid_o), 32'h1);
    chk("b2b_first", 32'(dut_word), 32'(pk(1, 0, 19'h20000, 0, 0, 0)));
    @(posedge clk);
    #1;
    chk("b2b_second", 32'(dut_word), 32'(pk(0, 1, 19'h7FFFF, 1, 0, 0)));
    @(posedge clk);
    #1;
    chk("b2b_idle", 32'(out_valid_o), 32'h0);
    drain();

    // Six-word stream with a 5-cycle output stall.
    sw = '{32'h3F800000, 32'h3FC00000, 32'h3F000000, 32'hBE800000, 32'h3F400000, 32'hBFC00000};
    se = '{pk(0, 1, 19'h00000, 0, 0, 0), pk(0, 1, 19'h40000, 0, 0, 0),
           pk(0, 0, 19'h40000, 0, 0, 0), pk(1, 0, 19'h20000, 0, 0, 0),
           pk(0, 0, 19'h60000, 0, 0, 0), pk(1, 1, 19'h40000, 0, 0, 0)};
    fork
      begin
        for (int i = 0; i < 6; i++) send(sw[i], se[i]);
      end
      begin
        t = 0;
        while (!out_valid_o && t < 20) begin
          @(posedge clk);
          #1;
          t++;
        end
        chk("stall_first_seen", 32'(out_valid_o), 32'h1);
        out_ready_i = 1'b0;
        snap        = dut_word;
        chk("stall_snap", 32'(snap), 32'(se[0]));
        for (int c = 0; c < 5; c++) begin
          @(posedge clk);
          #1;
          chk($sformatf("stall_hold%0d", c), 32'(dut_word), 32'(snap));
          chk($sformatf("stall_valid%0d", c), 32'(out_valid_o), 32'h1);
          chk($sformatf("stall_ready%0d", c), 32'(in_ready_o), 32'h0);
        end
        out_ready_i = 1'b1;
      end
    join
    drain();
    chk("stall_delivered", 32'(n_out), 32'(2 * tbl.size() + 8));

    // Reset with three words in flight.
    fp_i       = 32'h3F800000;
    in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    fp_i = 32'h3FC00000;
    @(posedge clk);
    #1;
    fp_i = 32'h3F000000;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    chk("flush_pre", 32'(out_valid_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("flush_valid", 32'(out_valid_o), 32'h0);
    chk("flush_word", 32'(dut_word), 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("flush_ready", 32'(in_ready_o), 32'h1);
    fp_i       = 32'hC0490FDB;
    in_valid_i = 1'b1;
    expq.push_back(pk(1, 1, 19'h7FFFF, 1, 0, 0));
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    chk("post_rst_c1", 32'(out_valid_o), 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_c2", 32'(out_valid_o), 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_c3", 32'(out_valid_o), 32'h1);
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("final_idle", 32'(out_valid_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
